// File: rtl/pipe_defs_pkg.sv
// rtl/pipe_defs_pkg.sv - shared stall encodings and FSM states for the pipeline sequencer
package pipe_defs;

  localparam int STALL_W      = 6;
  localparam int STALL_PC     = 0;
  localparam int STALL_IFID   = 1;
  localparam int STALL_IDEX   = 2;
  localparam int STALL_EXMEM  = 3;
  localparam int STALL_MEMWB  = 4;
  localparam int STALL_RSVD   = 5;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

  typedef logic [1:0] state_t;

  localparam state_t ST_RUN   = 2'd0;
  localparam state_t ST_MULTI = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage core with multi-cycle EX countdown
module pipeline_ctrl
  import pipe_defs::*;
#(
  parameter int CYC_W = 6,
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               ex_start,
  input  logic [CYC_W-1:0]   ex_cycles,
  input  logic               flush_req,
  input  logic [PC_W-1:0]    flush_pc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [PC_W-1:0]    new_pc,
  output logic               ex_done,
  output logic               busy,
  output logic [CNT_W-1:0]   stall_count
);

  state_t           state, state_nxt;
  logic [CYC_W-1:0] cnt, cnt_nxt;

  always_comb begin
    stall     = STALL_NONE;
    flush     = 1'b0;
    new_pc    = '0;
    ex_done   = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    if (rst) begin
      state_nxt = ST_RUN;
      cnt_nxt   = '0;
    end else if (flush_req) begin
      // flush wins over everything and abandons any in-flight long op
      flush     = 1'b1;
      new_pc    = flush_pc;
      state_nxt = ST_RUN;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_MULTI: begin
          stall   = STALL_EX;
          cnt_nxt = cnt - 1'b1;
          if (cnt == CYC_W'(1)) state_nxt = ST_DONE;
        end
        ST_DONE: begin
          ex_done   = 1'b1;
          stall     = stallreq_id ? STALL_ID : STALL_NONE;
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
        ST_RUN: begin
          if (stallreq_ex) begin
            stall = STALL_EX;
          end else if (ex_start && (ex_cycles != '0)) begin
            // the start cycle itself is the first of the N stall cycles
            stall     = STALL_EX;
            cnt_nxt   = ex_cycles - 1'b1;
            state_nxt = (ex_cycles == CYC_W'(1)) ? ST_DONE : ST_MULTI;
          end else if (stallreq_id) begin
            stall = STALL_ID;
          end
        end
        default: begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign busy = !rst && (state != ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall[STALL_PC]),
    .count (stall_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed and randomized bench for pipeline_ctrl against a cycle-timeline model
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id = 1'b0, stallreq_ex = 1'b0, ex_start = 1'b0, flush_req = 1'b0;
  logic [5:0]  ex_cycles = '0;
  logic [31:0] flush_pc = '0;
  logic [5:0]  stall, stall_b;
  logic        flush, ex_done, busy, flush_b, ex_done_b, busy_b;
  logic [31:0] new_pc, new_pc_b, stall_count;
  logic [3:0]  count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CYC_W(6), .PC_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .ex_start(ex_start), .ex_cycles(ex_cycles), .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .ex_done(ex_done), .busy(busy),
    .stall_count(stall_count)
  );

  pipeline_ctrl #(.CYC_W(6), .PC_W(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .ex_start(ex_start), .ex_cycles(ex_cycles), .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall_b), .flush(flush_b), .new_pc(new_pc_b), .ex_done(ex_done_b), .busy(busy_b),
    .stall_count(count_b)
  );

  // Reference: a long op started at cycle T with length N occupies EX until cycle T+N.
  int   cyc = 0;
  int   done_cycle = 0;
  bit   op_active = 0;
  int   m_count = 0;
  logic [5:0]  exp_stall;
  logic        exp_flush, exp_done, exp_busy;
  logic [31:0] exp_pc;

  always_comb begin
    exp_stall = 6'b000000;
    exp_flush = 1'b0;
    exp_done  = 1'b0;
    exp_busy  = 1'b0;
    exp_pc    = 32'h0;
    if (!rst) begin
      exp_busy = op_active;
      if (flush_req) begin
        exp_flush = 1'b1;
        exp_pc    = flush_pc;
      end else if (op_active && cyc < done_cycle) begin
        exp_stall = 6'b001111;
      end else if (op_active) begin
        exp_done  = 1'b1;
        exp_stall = stallreq_id ? 6'b000111 : 6'b000000;
      end else if (stallreq_ex || (ex_start && ex_cycles != 0)) begin
        exp_stall = 6'b001111;
      end else if (stallreq_id) begin
        exp_stall = 6'b000111;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      op_active = 0;
      m_count   = 0;
    end else begin
      if (exp_stall[0]) m_count++;
      if (flush_req) op_active = 0;
      else if (op_active) begin
        if (cyc == done_cycle) op_active = 0;
      end else if (!stallreq_ex && ex_start && ex_cycles != 0) begin
        op_active  = 1;
        done_cycle = cyc + int'(ex_cycles);
      end
    end
    cyc++;
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    stallreq_id = 0; stallreq_ex = 0; ex_start = 0; ex_cycles = 0; flush_req = 0; flush_pc = 0;
  endtask

  task automatic reset_dut();
    next(); rst = 1; set_idle();
    next(); rst = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      next(); rst = 1; stallreq_id = 1;
      @(negedge clk);
      checks++; if (stall !== 6'h00) begin errors++; $display("FAIL reset_stall: got %h expected 00", stall); end
      checks++; if (flush !== 1'b0 || busy !== 1'b0 || ex_done !== 1'b0) begin errors++; $display("FAIL reset_ctrl: flush=%b busy=%b ex_done=%b expected 0", flush, busy, ex_done); end
      checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", stall_count); end
    end
    next(); rst = 0;
    @(negedge clk);
    checks++; if (stall !== 6'b000111) begin errors++; $display("FAIL reset_release_stall: got %b expected 000111", stall); end
    checks++; if (stall_count !== 32'd0) begin errors++; $display("FAIL reset_release_count: got %0d expected 0", stall_count); end
  endtask

  task automatic test_multi_n3();
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      next(); ex_start = 1; ex_cycles = 3;
      @(negedge clk);
      checks++; if (stall !== (k < 3 ? 6'b001111 : 6'b000000)) begin errors++; $display("FAIL n3_stall[%0d]: got %b expected %b", k, stall, (k < 3 ? 6'b001111 : 6'b000000)); end
      checks++; if (ex_done !== (k == 3)) begin errors++; $display("FAIL n3_done[%0d]: got %b expected %b", k, ex_done, (k == 3)); end
      checks++; if (busy !== (k != 0)) begin errors++; $display("FAIL n3_busy[%0d]: got %b expected %b", k, busy, (k != 0)); end
    end
    next(); set_idle();
    @(negedge clk);
    checks++; if (stall_count !== 32'd3) begin errors++; $display("FAIL n3_count: got %0d expected 3", stall_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL n3_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_boundary_n();
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      next(); ex_start = 1; ex_cycles = 0;
      @(negedge clk);
      checks++; if (stall !== 6'h00 || ex_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL n0[%0d]: stall=%b done=%b busy=%b expected all 0", k, stall, ex_done, busy); end
    end
    next(); ex_start = 1; ex_cycles = 1;
    @(negedge clk);
    checks++; if (stall !== 6'b001111 || ex_done !== 1'b0) begin errors++; $display("FAIL n1_start: stall=%b done=%b expected 001111/0", stall, ex_done); end
    next();
    @(negedge clk);
    checks++; if (stall !== 6'h00 || ex_done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL n1_done: stall=%b done=%b busy=%b expected 000000/1/1", stall, ex_done, busy); end
    next(); set_idle();
    @(negedge clk);
    checks++; if (busy !== 1'b0 || ex_done !== 1'b0) begin errors++; $display("FAIL n1_after: busy=%b done=%b expected 0/0", busy, ex_done); end
  endtask

  task automatic test_abort();
    reset_dut();
    next(); ex_start = 1; ex_cycles = 5;
    @(negedge clk);
    checks++; if (stall !== 6'b001111) begin errors++; $display("FAIL abort_start: got %b expected 001111", stall); end
    next(); flush_req = 1; flush_pc = 32'hBFC00380;
    @(negedge clk);
    checks++; if (flush !== 1'b1 || new_pc !== 32'hBFC00380) begin errors++; $display("FAIL abort_flush: flush=%b new_pc=%h expected 1/bfc00380", flush, new_pc); end
    checks++; if (stall !== 6'h00 || ex_done !== 1'b0) begin errors++; $display("FAIL abort_stall: stall=%b done=%b expected 0/0", stall, ex_done); end
    next(); set_idle();
    @(negedge clk);
    checks++; if (busy !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL abort_run: busy=%b flush=%b expected 0/0", busy, flush); end
    for (int k = 0; k < 6; k++) begin
      next();
      @(negedge clk);
      checks++; if (ex_done !== 1'b0 || stall !== 6'h00) begin errors++; $display("FAIL abort_quiet[%0d]: done=%b stall=%b expected 0/0", k, ex_done, stall); end
    end
  endtask

  task automatic test_priority();
    reset_dut();
    for (int k = 0; k < 2; k++) begin
      next(); stallreq_ex = 1; ex_start = 1; ex_cycles = 2;
      @(negedge clk);
      checks++; if (stall !== 6'b001111 || busy !== 1'b0) begin errors++; $display("FAIL prio_ex[%0d]: stall=%b busy=%b expected 001111/0", k, stall, busy); end
    end
    for (int k = 0; k < 2; k++) begin
      next(); stallreq_ex = 0;
      @(negedge clk);
      checks++; if (stall !== 6'b001111 || busy !== (k == 1)) begin errors++; $display("FAIL prio_op[%0d]: stall=%b busy=%b expected 001111/%0d", k, stall, busy, k); end
    end
    next(); stallreq_id = 1; stallreq_ex = 1;
    @(negedge clk);
    checks++; if (stall !== 6'b000111 || ex_done !== 1'b1) begin errors++; $display("FAIL prio_done_id: stall=%b done=%b expected 000111/1", stall, ex_done); end
    next(); set_idle();
  endtask

  task automatic test_saturation();
    reset_dut();
    for (int k = 1; k <= 20; k++) begin
      next(); stallreq_id = 1;
      @(negedge clk);
      checks++; if (int'(count_b) !== ((k - 1 > 15) ? 15 : k - 1)) begin errors++; $display("FAIL sat_step[%0d]: got %0d expected %0d", k, count_b, ((k - 1 > 15) ? 15 : k - 1)); end
    end
    next(); set_idle();
    @(negedge clk);
    checks++; if (count_b !== 4'hF) begin errors++; $display("FAIL sat_final: got %h expected f", count_b); end
    checks++; if (stall_count !== 32'd20) begin errors++; $display("FAIL sat_wide: got %0d expected 20", stall_count); end
  endtask

  task automatic test_random();
    reset_dut();
    for (int k = 0; k < 600; k++) begin
      next();
      rst         = ($urandom_range(0, 79) == 0);
      flush_req   = ($urandom_range(0, 15) == 0);
      flush_pc    = $urandom;
      stallreq_id = ($urandom_range(0, 3) == 0);
      stallreq_ex = ($urandom_range(0, 5) == 0);
      ex_start    = ($urandom_range(0, 2) != 0);
      ex_cycles   = 6'($urandom_range(0, 6));
      @(negedge clk);
      checks++; if (stall !== exp_stall) begin errors++; $display("FAIL rnd_stall[%0d]: got %b expected %b", k, stall, exp_stall); end
      checks++; if (flush !== exp_flush || ex_done !== exp_done || busy !== exp_busy) begin errors++; $display("FAIL rnd_ctrl[%0d]: flush/done/busy got %b%b%b expected %b%b%b", k, flush, ex_done, busy, exp_flush, exp_done, exp_busy); end
      if (exp_flush) begin
        checks++; if (new_pc !== exp_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", k, new_pc, exp_pc); end
      end
      checks++; if (stall_count !== 32'(m_count)) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", k, stall_count, m_count); end
      checks++; if (int'(count_b) !== ((m_count > 15) ? 15 : m_count)) begin errors++; $display("FAIL rnd_sat[%0d]: got %0d expected %0d", k, count_b, ((m_count > 15) ? 15 : m_count)); end
    end
    next(); rst = 0; set_idle();
  endtask

  initial begin
    test_reset();
    test_multi_n3();
    test_boundary_n();
    test_abort();
    test_priority();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS core.
- Generates the per-stage stall vector for the pc, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the flush and new-PC signals used on exceptions and eret.
- Owns the multi-cycle EX timing (div/madd) with an internal countdown FSM, so the ID/EX register holds its contents while a long operation completes.
- Keeps a saturating count of stall cycles for performance debug.

Parameters:
- CYC_W, 6, width of the multi-cycle length input/counter.
- PC_W, 32, width of the flush target PC.
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- stallreq_id  in  1  load-use hazard request from insDecode (level).
- stallreq_ex  in  1  generic EX busy request (level).
- ex_start  in  1  EX holds a multi-cycle op; held high while that instruction sits in EX.
- ex_cycles  in  CYC_W  stall length N for the op; sampled with ex_start.
- flush_req  in  1  exception/eret flush request from MEM.
- flush_pc  in  PC_W  redirect target, valid with flush_req.
- stall  out  6  bit0 pc, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved (always 0).
- flush  out  1  clear all pipeline registers this cycle.
- new_pc  out  PC_W  redirect PC, valid when flush=1.
- ex_done  out  1  multi-cycle result valid; the EX instruction advances this cycle.
- busy  out  1  FSM not in RUN.
- stall_count  out  CNT_W  number of cycles with stall[0]=1.

Behaviour:
- Reset (sync, rst=1 at a posedge):
  - state=RUN, cnt=0, stall_count=0.
  - While rst is high, outputs are forced: stall=0, flush=0, new_pc=0, ex_done=0, busy=0.
- stall, flush, new_pc and ex_done are combinational from the state, cnt and the current inputs. Hazards take effect in the same cycle they are raised.
- Decode constants:
  - STALL_NONE=6'b000000
  - STALL_ID=6'b000111
  - STALL_EX=6'b001111
- Priority, highest first: flush_req > FSM in MULTI > stallreq_ex > ex_start > stallreq_id.
- flush_req=1, any state:
  - Outputs: flush=1, new_pc=flush_pc, stall=STALL_NONE, ex_done=0.
  - Next: state=RUN, cnt=0. An in-flight multi-cycle op is aborted and no ex_done is produced.
- RUN:
  - stallreq_ex=1: stall=STALL_EX; ex_start is ignored this cycle.
  - Else ex_start=1 and N≠0: stall=STALL_EX, cnt<=N-1, state<= (N==1 ? DONE : MULTI).
  - Else ex_start=1 and N=0: no stall and no state change; ex_start is ignored.
  - Else stallreq_id=1: stall=STALL_ID.
  - Else stall=STALL_NONE.
- MULTI:
  - stall=STALL_EX; stallreq_id, stallreq_ex and ex_start are ignored.
  - cnt decrements each cycle; when cnt==1 the next state is DONE.
- DONE (exactly one cycle):
  - ex_done=1; ex_start is ignored (it is still high for the finishing instruction).
  - stall=STALL_ID if stallreq_id=1, else STALL_NONE.
  - stallreq_ex is ignored.
  - Next state is RUN.
- Timing: ex_start with N≥1 at cycle T gives stall=STALL_EX for cycles T..T+N-1 and ex_done=1 at T+N.
- busy=1 in MULTI or DONE.
- stall_count increments at each posedge where stall[0]=1, saturating at all-ones. It does not count during rst.

Decomposition:
- Shared package/header `pipe_defs`:
  - stall bit indices
  - STALL_NONE/ID/EX constants
  - state encoding RUN=2'd0, MULTI=2'd1, DONE=2'd2
- One natural sub-module, `sat_counter` (parameter W, inc, rst, count), for stall_count.
- The FSM and decode stay in pipeline_ctrl.

Test Plan:
- Reset: hold rst=1 for 2 cycles with stallreq_id=1 → stall=0, flush=0, busy=0, stall_count=0. After release, stall=6'b000111 in the same cycle.
- Multi-cycle, N=3: ex_start=1, ex_cycles=3 at T → stall=6'b001111 at T, T+1, T+2; ex_done=1 and stall=0 at T+3; busy=1 for T+1..T+3; stall_count=3.
- Boundary N: N=0 → no stall and no ex_done. N=1 → stall only at T, ex_done at T+1.
- Abort: flush_req=1, flush_pc=32'hBFC00380 at T+1 of an N=5 op → flush=1, new_pc=32'hBFC00380, stall=0 at T+1; state RUN at T+2; ex_done never asserts.
- Priority: stallreq_ex=1 with ex_start=1 (N=2) for 2 cycles, then stallreq_ex=0 → STALL_EX for 2 cycles, then the op starts with 2 more STALL_EX cycles, then ex_done. stallreq_id=1 during DONE → stall=6'b000111 with ex_done=1.
- Saturation: CNT_W=4, continuous stallreq_id for 20 cycles → stall_count stops at 4'hF.
